mips_dmem_responder: RTL and testbench

//  Data-memory responder on the MIPS core's store/load port (memwrite, ALU address, write data).

---
 rtl/mips_mem_pkg.sv | 12 +
 rtl/mips_dmem_responder_store_log_fifo.sv | 63 ++++++
 rtl/mips_dmem_responder.sv | 109 ++++++++++
 tb/tb_mips_dmem_responder.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/mips_mem_pkg.sv
// Shared types and constants for the MIPS data-memory responder and its store log.
package mips_mem_pkg;

    localparam int WORD_W = 32;
    localparam logic [WORD_W-1:0] HALT_ADDR_DEFAULT = 32'h44;

    typedef struct packed {
        logic [WORD_W-1:0] addr;
        logic [WORD_W-1:0] data;
    } store_evt_t;

endpackage

// File: rtl/mips_dmem_responder_store_log_fifo.sv
// Show-ahead synchronous FIFO recording accepted stores; drops pushes when full
// (unless a pop frees a slot on the same edge) and flags the drop as sticky overflow.
module store_log_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o,
    output logic             overflow_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] buf_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             overflow_q;
    logic             do_pop;
    logic             do_push;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full_o     = (count_q == CNT_W'(DEPTH));
    assign empty_o    = (count_q == '0);
    assign do_pop     = pop_i && !empty_o;
    assign do_push    = push_i && (!full_o || do_pop);
    assign dout_o     = buf_q[rd_ptr_q];
    assign count_o    = count_q;
    assign overflow_o = overflow_q;

    // NOTE: non-blocking assignments keep every register sampling pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (do_push) wr_ptr_q <= next_ptr(wr_ptr_q);
            if (do_pop)  rd_ptr_q <= next_ptr(rd_ptr_q);
            if (do_push && !do_pop)      count_q <= count_q + 1'b1;
            else if (do_pop && !do_push) count_q <= count_q - 1'b1;
            if (push_i && full_o && !do_pop) overflow_q <= 1'b1;
        end
    end

    // NOTE: storage arrays carry no reset; validity is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (do_push) buf_q[wr_ptr_q] <= din_i;
    end

endmodule

// File: rtl/mips_dmem_responder.sv
// Data-memory responder: combinational loads, clocked word stores, halt mailbox,
// sticky address-error flag and a store-event log for benches to pop.
module mips_dmem_responder
    import mips_mem_pkg::*;
#(
    parameter int          DEPTH     = 64,
    parameter int          LOG_DEPTH = 4,
    parameter logic [31:0] HALT_ADDR = HALT_ADDR_DEFAULT,
    parameter int          LOG_CNT_W = $clog2(LOG_DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 memwrite,
    input  logic [31:0]          addr,
    input  logic [31:0]          wdata,
    output logic [31:0]          rdata,
    output logic                 halt,
    output logic [31:0]          halt_data,
    output logic                 addr_err,
    output logic                 log_valid,
    output logic [31:0]          log_addr,
    output logic [31:0]          log_data,
    input  logic                 log_ready,
    output logic [LOG_CNT_W-1:0] log_count,
    output logic                 log_overflow
);

    localparam int          AW        = $clog2(DEPTH);
    localparam logic [31:0] RAM_BYTES = 32'(4 * DEPTH);

    logic [WORD_W-1:0] mem_q [DEPTH];
    logic              halt_q, halt_d;
    logic [31:0]       halt_data_q, halt_data_d;
    logic              addr_err_q, addr_err_d;

    logic          is_mbox, aligned, in_ram, bad_store, accept, ram_we, log_empty, log_full;
    logic [AW-1:0] word_idx;
    store_evt_t    push_evt, head_evt;

    assign is_mbox   = (addr == HALT_ADDR);
    assign aligned   = (addr[1:0] == 2'b00);
    assign in_ram    = aligned && (addr < RAM_BYTES);
    assign word_idx  = addr[AW+1:2];
    assign bad_store = !aligned || (!in_ram && !is_mbox);
    assign accept    = memwrite && !bad_store && !halt_q;
    assign ram_we    = accept && !is_mbox;
    assign push_evt  = '{addr: addr, data: wdata};

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        rdata = '0;
        if (is_mbox)     rdata = halt_data_q;
        else if (in_ram) rdata = mem_q[word_idx];
    end

    always_comb begin
        halt_d      = halt_q;
        halt_data_d = halt_data_q;
        addr_err_d  = addr_err_q;
        if (memwrite && bad_store) begin
            addr_err_d = 1'b1;
        end else if (accept && is_mbox) begin
            halt_d      = 1'b1;
            halt_data_d = wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            halt_q      <= 1'b0;
            halt_data_q <= '0;
            addr_err_q  <= 1'b0;
        end else begin
            halt_q      <= halt_d;
            halt_data_q <= halt_data_d;
            addr_err_q  <= addr_err_d;
        end
    end

    // RAM deliberately survives reset so a program image outlives a mid-run reset.
    always_ff @(posedge clk) begin
        if (ram_we) mem_q[word_idx] <= wdata;
    end

    store_log_fifo #(
        .WIDTH ($bits(store_evt_t)),
        .DEPTH (LOG_DEPTH),
        .CNT_W (LOG_CNT_W)
    ) u_log (
        .clk        (clk),
        .reset      (reset),
        .push_i     (accept),
        .pop_i      (log_ready),
        .din_i      (push_evt),
        .dout_o     (head_evt),
        .full_o     (log_full),
        .empty_o    (log_empty),
        .count_o    (log_count),
        .overflow_o (log_overflow)
    );

    assign halt      = halt_q;
    assign halt_data = halt_data_q;
    assign addr_err  = addr_err_q;
    assign log_valid = !log_empty;
    assign log_addr  = head_evt.addr;
    assign log_data  = head_evt.data;

endmodule

// File: tb/tb_mips_dmem_responder.sv
// Bench for mips_dmem_responder: directed scenarios plus random traffic checked
// every cycle against a queue/array reference model.
module tb_mips_dmem_responder;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        memwrite = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        log_ready = 1'b0;
    logic [31:0] rdata, halt_data, log_addr, log_data;
    logic        halt, addr_err, log_valid, log_overflow;
    logic [2:0]  log_count;

    mips_dmem_responder dut (
        .clk          (clk),
        .reset        (reset),
        .memwrite     (memwrite),
        .addr         (addr),
        .wdata        (wdata),
        .rdata        (rdata),
        .halt         (halt),
        .halt_data    (halt_data),
        .addr_err     (addr_err),
        .log_valid    (log_valid),
        .log_addr     (log_addr),
        .log_data     (log_data),
        .log_ready    (log_ready),
        .log_count    (log_count),
        .log_overflow (log_overflow)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit cmp_en = 1'b0;

    // Reference model state
    logic [31:0] m_mem [64];
    bit          m_known [64];
    bit          m_halt, m_err, m_ovf;
    logic [31:0] m_hd;
    logic [31:0] qa [$];
    logic [31:0] qd [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_halt = 0; m_err = 0; m_ovf = 0; m_hd = '0;
        qa.delete(); qd.delete();
    endtask

    // Apply the store/log rules to the inputs present at this clock edge.
    task automatic model_step();
        bit bad, acc, popping;
        acc = 0;
        if (reset) return;
        popping = (qa.size() > 0) && log_ready;
        if (memwrite) begin
            bad = (addr[1:0] != 2'b00) || (addr >= 32'd256 && addr != 32'h44);
            if (bad) m_err = 1;
            else if (!m_halt) begin
                acc = 1;
                if (addr == 32'h44) begin
                    m_halt = 1;
                    m_hd   = wdata;
                end else begin
                    m_mem[addr / 4]   = wdata;
                    m_known[addr / 4] = 1;
                end
            end
        end
        if (popping) begin
            void'(qa.pop_front());
            void'(qd.pop_front());
        end
        if (acc) begin
            if (qa.size() < 4) begin
                qa.push_back(addr);
                qd.push_back(wdata);
            end else m_ovf = 1;
        end
    endtask

    logic [31:0] exp_rd;
    bit          exp_rd_ok;

    always @(negedge clk) begin
        if (cmp_en) begin
            exp_rd_ok = 1;
            exp_rd    = '0;
            if (addr == 32'h44) exp_rd = m_hd;
            else if (addr[1:0] == 2'b00 && addr < 32'd256) begin
                exp_rd_ok = m_known[addr / 4];
                exp_rd    = m_mem[addr / 4];
            end
            if (exp_rd_ok) check("rdata", rdata, exp_rd);
            check("halt", {31'b0, halt}, {31'b0, m_halt});
            check("halt_data", halt_data, m_hd);
            check("addr_err", {31'b0, addr_err}, {31'b0, m_err});
            check("log_overflow", {31'b0, log_overflow}, {31'b0, m_ovf});
            check("log_valid", {31'b0, log_valid}, {31'b0, qa.size() > 0});
            check("log_count", {29'b0, log_count}, 32'(qa.size()));
            if (qa.size() > 0) begin
                check("log_addr", log_addr, qa[0]);
                check("log_data", log_data, qd[0]);
            end
        end
    end

    // One clock cycle with the given inputs; returns at posedge+1 with the bus idle.
    task automatic cycle(input bit mw, input logic [31:0] a, input logic [31:0] d, input bit rdy);
        memwrite = mw; addr = a; wdata = d; log_ready = rdy;
        @(posedge clk);
        model_step();
        #1;
        memwrite = 0; log_ready = 0;
    endtask

    task automatic probe(input logic [31:0] a, input logic [31:0] exp, input string name);
        addr = a;
        #1;
        check(name, rdata, exp);
    endtask

    logic [31:0] drain_exp [4];
    logic [31:0] ra;

    initial begin
        model_reset();
        for (int i = 0; i < 64; i++) m_known[i] = 0;
        cmp_en = 1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_halt", {31'b0, halt}, 32'd0);
        check("rst_log_valid", {31'b0, log_valid}, 32'd0);
        check("rst_log_count", {29'b0, log_count}, 32'd0);
        reset = 0;

        // Basic store and log
        cycle(1, 32'h10, 32'hDEADBEEF, 0);
        probe(32'h10, 32'hDEADBEEF, "t1_rdata");
        check("t1_log_valid", {31'b0, log_valid}, 32'd1);
        check("t1_log_addr", log_addr, 32'h10);
        check("t1_log_data", log_data, 32'hDEADBEEF);

        // Bad addresses
        cycle(1, 32'h22, 32'h7, 0);
        check("t3_err", {31'b0, addr_err}, 32'd1);
        check("t3_count", {29'b0, log_count}, 32'd1);
        cycle(1, 32'h100, 32'h9, 0);
        check("t3_err_sticky", {31'b0, addr_err}, 32'd1);
        probe(32'h100, 32'h0, "t3_rdata_oor");
        cycle(0, 32'h0, 32'h0, 1);

        // Overflow, then push+pop while full
        for (int i = 0; i < 4; i++) cycle(1, 32'h80 + 32'(4 * i), 32'hA000 + 32'(i), 0);
        check("t4_count4", {29'b0, log_count}, 32'd4);
        cycle(1, 32'h90, 32'hA004, 0);
        check("t4_ovf", {31'b0, log_overflow}, 32'd1);
        check("t4_count_sat", {29'b0, log_count}, 32'd4);
        probe(32'h90, 32'hA004, "t4_ram_on_drop");
        cycle(1, 32'h94, 32'hA005, 1);
        check("t4_count_pp", {29'b0, log_count}, 32'd4);
        check("t4_head", log_addr, 32'h84);

        // Drain in order
        drain_exp = '{32'h84, 32'h88, 32'h8C, 32'h94};
        for (int i = 0; i < 4; i++) begin
            check("t6_order", log_addr, drain_exp[i]);
            cycle(0, 32'h0, 32'h0, 1);
        end
        check("t6_valid0", {31'b0, log_valid}, 32'd0);
        check("t6_count0", {29'b0, log_count}, 32'd0);

        // Halt mailbox
        cycle(1, 32'h20, 32'h11112222, 1);
        cycle(1, 32'h44, 32'h1A, 0);
        check("t2_halt", {31'b0, halt}, 32'd1);
        check("t2_halt_data", halt_data, 32'h1A);
        probe(32'h44, 32'h1A, "t2_rdata_mbox");
        cycle(1, 32'h20, 32'h5, 0);
        check("t2_count_frozen", {29'b0, log_count}, 32'd2);
        probe(32'h20, 32'h11112222, "t2_ram_frozen");

        // Asynchronous reset between edges
        #2;
        reset = 1;
        #1;
        model_reset();
        check("t5_halt", {31'b0, halt}, 32'd0);
        check("t5_err", {31'b0, addr_err}, 32'd0);
        check("t5_ovf", {31'b0, log_overflow}, 32'd0);
        check("t5_valid", {31'b0, log_valid}, 32'd0);
        check("t5_count", {29'b0, log_count}, 32'd0);
        #2;
        reset = 0;
        probe(32'h10, 32'hDEADBEEF, "t5_ram_kept");
        @(posedge clk);
        #1;

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            case ($urandom_range(0, 15))
                0:       ra = {24'b0, 6'($urandom_range(0, 63)), 2'($urandom_range(1, 3))};
                1:       ra = 32'h100 + 32'(4 * $urandom_range(0, 63));
                2:       ra = $urandom;
                3:       ra = ($urandom_range(0, 3) == 0) ? 32'h44 : 32'h40;
                default: ra = {24'b0, 6'($urandom_range(0, 63)), 2'b00};
            endcase
            cycle(1'($urandom_range(0, 2) != 0), ra, $urandom, 1'($urandom_range(0, 2) == 0));
            if ($urandom_range(0, 149) == 0) begin
                reset = 1;
                #1;
                model_reset();
                #1;
                reset = 0;
            end
        end

        cmp_en = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
